alu_arbiter: RTL and testbench
==============================

ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter ALU_LAT, default 2: cycles from alu_inst_o issue cycle to valid alu_data_i; legal values >= 1.
REQ-002 clk_p_i  input  1  single clock; all logic on rising edge.
REQ-003 reset_p_i  input  1  reset; synchronous, active-high.
REQ-004 reqK_valid_i  input  1  (K=0,1) request pending.
REQ-005 reqK_ready_o  output  1  (K=0,1) request accepted this cycle when valid also high.
REQ-006 reqK_a_i, reqK_b_i  input  8 each  (K=0,1) operands.
REQ-007 reqK_op_i  input  3  (K=0,1) opcode 000 ADD, 001 SUB, 010 MUL, 011 DIV, 100 NOT, 101 XOR, 110 ABS, 111 reserved.
REQ-008 alu_a_o, alu_b_o  output  8 each  registered operands to shared ALU.
REQ-009 alu_inst_o  output  3  registered instruction to ALU; 111 = hold mode.
REQ-010 alu_data_i  input  16  ALU result.
REQ-011 rsp_valid_o  output  1  one-cycle response pulse; no backpressure.
REQ-012 rsp_id_o  output  1  requester index of response.
REQ-013 rsp_data_o  output  16  result.
REQ-014 rsp_err_o  output  1  request rejected (op 111).

Function
REQ-015 Block SHALL hold at most one transaction in flight; FSM states IDLE, DETOUR, ISSUE, WAIT, RESP.
REQ-016 Arbitration in IDLE SHALL be round-robin: one valid requester wins; if both valid, requester not served last wins; last-served pointer resets to 1 (req0 wins first).
REQ-017 reqK_ready_o SHALL be high only in IDLE for the granted requester (combinational from valids and pointer); handshake = valid & ready same cycle; requester holds data stable until accepted.
REQ-018 Block SHALL keep mode mirror register (reset 000), updated to op on each issued non-111 instruction.
REQ-019 Directly reachable ops per mode: 000/001 -> any of 000-110; 010 -> 000,001,010,011,101; 011 -> 000,001,011,110; 100 -> 001,100,101; 101 -> 000,001,010,101; 110 -> 001,101,110.
REQ-020 Accept at cycle t, op reachable: ISSUE at t+1 (alu_inst_o=op, alu_a/b_o=operands).
REQ-021 Accept at t, op unreachable: DETOUR at t+1 (alu_inst_o=001, result discarded, mirror=001), ISSUE at t+2.
REQ-022 Outside ISSUE/DETOUR alu_inst_o SHALL be 111; alu_a/b_o hold last value.
REQ-023 alu_data_i SHALL be sampled in cycle issue+ALU_LAT; rsp_valid_o, rsp_data_o, rsp_id_o asserted one cycle later (default: t+4 direct, t+5 detour).
REQ-024 FSM SHALL be in IDLE during the RESP cycle, so a new accept may coincide with rsp_valid_o.
REQ-025 Op 111 SHALL be accepted, never issued; rsp_valid_o=1, rsp_err_o=1, rsp_data_o=0 at t+1; mirror unchanged.
REQ-026 rsp_err_o SHALL be 0 on all other responses; rsp_data_o/rsp_id_o hold last value when rsp_valid_o=0.
REQ-027 Last-served pointer SHALL update on accept, including op-111 accepts.

Reset
REQ-028 reset_p_i high at a clock edge SHALL force IDLE, mirror 000, pointer 1, alu_inst_o 111, alu_a/b_o 0, rsp_valid_o 0, rsp_err_o 0, rsp_data_o 0, rsp_id_o 0; in-flight transaction discarded, no response.
REQ-029 Shared ALU SHALL be reset in the same cycle as this block (system requirement) so mirror matches ALU mode.

Verification
REQ-030 After reset, req0 ADD a=3 b=5 accepted t -> alu_inst_o=000 at t+1; rsp_valid_o t+4, data 0x0008, id 0, err 0.
REQ-031 req0 and req1 valid same cycle after reset -> req0 accepted first, req1 accepted in req0's RESP cycle; with both held valid, grants alternate 0,1,0,1.
REQ-032 MUL (mode 010), then NOT a=1 b=3 -> DETOUR alu_inst_o=001 then 100; rsp at t+5, data 0xFFFD.
REQ-033 req1 op 111 -> rsp t+1 with err 1, data 0x0000, id 1; alu_inst_o stays 111; next ABS from mode 000 issues directly.
REQ-034 reset_p_i asserted during WAIT -> no rsp_valid_o, next cycle IDLE with ready available, mirror 000.

Source files
------------

// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end for a shared, mode-stateful ALU.
// Tracks ALU mode, inserts a SUB detour for unreachable ops, returns results.
module alu_arbiter #(
    parameter int ALU_LAT = 2
) (
    input  logic        clk_p_i,
    input  logic        reset_p_i,

    input  logic        req0_valid_i,
    output logic        req0_ready_o,
    input  logic [7:0]  req0_a_i,
    input  logic [7:0]  req0_b_i,
    input  logic [2:0]  req0_op_i,

    input  logic        req1_valid_i,
    output logic        req1_ready_o,
    input  logic [7:0]  req1_a_i,
    input  logic [7:0]  req1_b_i,
    input  logic [2:0]  req1_op_i,

    output logic [7:0]  alu_a_o,
    output logic [7:0]  alu_b_o,
    output logic [2:0]  alu_inst_o,
    input  logic [15:0] alu_data_i,

    output logic        rsp_valid_o,
    output logic        rsp_id_o,
    output logic [15:0] rsp_data_o,
    output logic        rsp_err_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DETOUR,
        S_ISSUE,
        S_WAIT,
        S_RESP
    } state_t;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_MUL  = 3'b010;
    localparam logic [2:0] OP_DIV  = 3'b011;
    localparam logic [2:0] OP_NOT  = 3'b100;
    localparam logic [2:0] OP_XOR  = 3'b101;
    localparam logic [2:0] OP_ABS  = 3'b110;
    localparam logic [2:0] OP_HOLD = 3'b111;

    // Counter spans the cycles between ISSUE and the sampling cycle.
    localparam int CW = (ALU_LAT > 2) ? $clog2(ALU_LAT) : 1;
    localparam logic [CW-1:0] WAIT_LAST = CW'((ALU_LAT >= 2) ? ALU_LAT - 2 : 0);

    // Which ops the ALU can switch to directly from its current mode.
    function automatic logic reachable(input logic [2:0] mode,
                                       input logic [2:0] op);
        logic [7:0] mask;
        mask = 8'h00;
        case (mode)
            OP_ADD:  mask = 8'b0111_1111;
            OP_SUB:  mask = 8'b0111_1111;
            OP_MUL:  mask = 8'b0010_1111;
            OP_DIV:  mask = 8'b0100_1011;
            OP_NOT:  mask = 8'b0011_0010;
            OP_XOR:  mask = 8'b0010_0111;
            OP_ABS:  mask = 8'b0110_0010;
            default: mask = 8'h00;
        endcase
        return mask[op];
    endfunction

    state_t state_q, state_d;

    logic [2:0]    mode_q;
    logic          last_q;
    logic [CW-1:0] cnt_q;

    logic [2:0] pend_op_q;
    logic [7:0] pend_a_q;
    logic [7:0] pend_b_q;
    logic       pend_id_q;

    logic       gnt0, gnt1, accept;
    logic [2:0] acc_op;
    logic [7:0] acc_a, acc_b;
    logic [2:0] iss_op;
    logic [7:0] iss_a, iss_b;
    logic       err_rsp;

    // Round-robin grant: a lone requester wins, ties go to the one not served last.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (state_q == S_IDLE) begin
            gnt0 = req0_valid_i && (!req1_valid_i || last_q);
            gnt1 = req1_valid_i && (!req0_valid_i || !last_q);
        end
        accept = gnt0 | gnt1;
        acc_op = gnt1 ? req1_op_i : req0_op_i;
        acc_a  = gnt1 ? req1_a_i  : req0_a_i;
        acc_b  = gnt1 ? req1_b_i  : req0_b_i;
    end

    assign req0_ready_o = gnt0;
    assign req1_ready_o = gnt1;

    // Operands for the next ALU issue: fresh from the winner in IDLE, else latched.
    always_comb begin
        iss_op = pend_op_q;
        iss_a  = pend_a_q;
        iss_b  = pend_b_q;
        if (state_q == S_IDLE) begin
            iss_op = acc_op;
            iss_a  = acc_a;
            iss_b  = acc_b;
        end
    end

    // Next-state logic for the single-transaction sequencer.
    always_comb begin
        state_d = state_q;
        err_rsp = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (acc_op == OP_HOLD) begin
                        err_rsp = 1'b1;
                    end else if (reachable(mode_q, acc_op)) begin
                        state_d = S_ISSUE;
                    end else begin
                        state_d = S_DETOUR;
                    end
                end
            end
            S_DETOUR: state_d = S_ISSUE;
            S_ISSUE: begin
                if (ALU_LAT == 1) begin
                    state_d = S_RESP;
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (cnt_q == WAIT_LAST) begin
                    state_d = S_RESP;
                end
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk_p_i) begin
        if (reset_p_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Latch the accepted request and track the last-served requester.
    always_ff @(posedge clk_p_i) begin
        if (reset_p_i) begin
            pend_op_q <= OP_ADD;
            pend_a_q  <= 8'h00;
            pend_b_q  <= 8'h00;
            pend_id_q <= 1'b0;
            last_q    <= 1'b1;
        end else if (accept) begin
            pend_op_q <= acc_op;
            pend_a_q  <= acc_a;
            pend_b_q  <= acc_b;
            pend_id_q <= gnt1;
            last_q    <= gnt1;
        end
    end

    // Drive the ALU and keep the mode mirror in step with what was issued.
    always_ff @(posedge clk_p_i) begin
        if (reset_p_i) begin
            alu_inst_o <= OP_HOLD;
            alu_a_o    <= 8'h00;
            alu_b_o    <= 8'h00;
            mode_q     <= OP_ADD;
        end else begin
            alu_inst_o <= OP_HOLD;
            if (state_d == S_DETOUR) begin
                alu_inst_o <= OP_SUB;
                alu_a_o    <= iss_a;
                alu_b_o    <= iss_b;
                mode_q     <= OP_SUB;
            end else if (state_d == S_ISSUE) begin
                alu_inst_o <= iss_op;
                alu_a_o    <= iss_a;
                alu_b_o    <= iss_b;
                mode_q     <= iss_op;
            end
        end
    end

    // Latency counter for the WAIT phase.
    always_ff @(posedge clk_p_i) begin
        if (reset_p_i) begin
            cnt_q <= '0;
        end else if (state_q == S_WAIT) begin
            cnt_q <= cnt_q + CW'(1);
        end else begin
            cnt_q <= '0;
        end
    end

    // Response pulse: ALU result after RESP, or an immediate error for op 111.
    always_ff @(posedge clk_p_i) begin
        if (reset_p_i) begin
            rsp_valid_o <= 1'b0;
            rsp_err_o   <= 1'b0;
            rsp_data_o  <= 16'h0000;
            rsp_id_o    <= 1'b0;
        end else begin
            rsp_valid_o <= 1'b0;
            rsp_err_o   <= 1'b0;
            if (state_q == S_RESP) begin
                rsp_valid_o <= 1'b1;
                rsp_data_o  <= alu_data_i;
                rsp_id_o    <= pend_id_q;
            end else if (err_rsp) begin
                rsp_valid_o <= 1'b1;
                rsp_err_o   <= 1'b1;
                rsp_data_o  <= 16'h0000;
                rsp_id_o    <= gnt1;
            end
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter with a latency-2 mock ALU.
// Directed vectors push expected responses; a monitor pops and compares.
module tb_alu_arbiter;

    localparam logic [2:0] ADD = 3'b000;
    localparam logic [2:0] SUB = 3'b001;
    localparam logic [2:0] MUL = 3'b010;
    localparam logic [2:0] DIV = 3'b011;
    localparam logic [2:0] NOP = 3'b100;
    localparam logic [2:0] XOR = 3'b101;
    localparam logic [2:0] ABS = 3'b110;
    localparam logic [2:0] HLD = 3'b111;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req0_valid_i = 1'b0, req1_valid_i = 1'b0;
    logic        req0_ready_o, req1_ready_o;
    logic [7:0]  req0_a_i = 8'h0, req0_b_i = 8'h0;
    logic [7:0]  req1_a_i = 8'h0, req1_b_i = 8'h0;
    logic [2:0]  req0_op_i = 3'h0, req1_op_i = 3'h0;
    logic [7:0]  alu_a_o, alu_b_o;
    logic [2:0]  alu_inst_o;
    logic [15:0] alu_data_i;
    logic        rsp_valid_o, rsp_id_o, rsp_err_o;
    logic [15:0] rsp_data_o;

    alu_arbiter #(.ALU_LAT(2)) dut (
        .clk_p_i(clk), .reset_p_i(reset),
        .req0_valid_i(req0_valid_i), .req0_ready_o(req0_ready_o),
        .req0_a_i(req0_a_i), .req0_b_i(req0_b_i), .req0_op_i(req0_op_i),
        .req1_valid_i(req1_valid_i), .req1_ready_o(req1_ready_o),
        .req1_a_i(req1_a_i), .req1_b_i(req1_b_i), .req1_op_i(req1_op_i),
        .alu_a_o(alu_a_o), .alu_b_o(alu_b_o), .alu_inst_o(alu_inst_o),
        .alu_data_i(alu_data_i),
        .rsp_valid_o(rsp_valid_o), .rsp_id_o(rsp_id_o),
        .rsp_data_o(rsp_data_o), .rsp_err_o(rsp_err_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Mock ALU: result of the instruction seen two cycles earlier.
    logic [18:0] p1 = 19'h0, p2 = 19'h0;
    always @(posedge clk) begin
        p1 <= {alu_inst_o, alu_a_o, alu_b_o};
        p2 <= p1;
    end
    always_comb begin
        logic [15:0] ea, eb;
        ea = {8'h00, p2[15:8]};
        eb = {8'h00, p2[7:0]};
        alu_data_i = 16'hDEAD;
        case (p2[18:16])
            ADD: alu_data_i = ea + eb;
            SUB: alu_data_i = ea - eb;
            MUL: alu_data_i = ea * eb;
            DIV: alu_data_i = (eb == 0) ? 16'hFFFF : ea / eb;
            NOP: alu_data_i = ea + ~eb;
            XOR: alu_data_i = ea ^ eb;
            ABS: alu_data_i = p2[15] ? 16'(-$signed(p2[15:8])) : ea;
            default: alu_data_i = 16'hDEAD;
        endcase
    end

    typedef struct {
        int          cyc;
        int          id;
        logic [15:0] data;
        logic        err;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   glog[$];
    int   gcyc[$];
    int   nchecks = 0;
    int   nfail = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] req);
        nchecks++;
        if (act !== req) begin
            nfail++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    // Monitor: every response pulse is matched against the scoreboard head.
    always @(negedge clk) begin
        if (rsp_valid_o) begin
            nchecks++;
            if (exp_q.size() == 0) begin
                nfail++;
                $display("FAIL rsp_unexpected cyc=%0d id=%0d data=%h", cyc,
                         rsp_id_o, rsp_data_o);
            end else begin
                mon_e = exp_q.pop_front();
                if (cyc != mon_e.cyc || rsp_id_o !== mon_e.id[0] ||
                    rsp_data_o !== mon_e.data || rsp_err_o !== mon_e.err) begin
                    nfail++;
                    $display("FAIL rsp actual cyc=%0d id=%0d data=%h err=%b required cyc=%0d id=%0d data=%h err=%b",
                             cyc, rsp_id_o, rsp_data_o, rsp_err_o,
                             mon_e.cyc, mon_e.id, mon_e.data, mon_e.err);
                end
            end
        end
    end

    task automatic drive(input int k, input logic [2:0] op,
                         input logic [7:0] a, input logic [7:0] b,
                         input logic [15:0] d, input int lat,
                         input logic err, input bit push,
                         output int acc);
        logic rdy;
        if (k == 0) begin
            req0_valid_i = 1'b1; req0_op_i = op; req0_a_i = a; req0_b_i = b;
        end else begin
            req1_valid_i = 1'b1; req1_op_i = op; req1_a_i = a; req1_b_i = b;
        end
        acc = -1;
        for (int i = 0; i < 60 && acc < 0; i++) begin
            @(negedge clk);
            rdy = (k == 0) ? req0_ready_o : req1_ready_o;
            if (rdy) acc = cyc;
        end
        if (acc < 0) begin
            nchecks++;
            nfail++;
            $display("FAIL accept_timeout req=%0d actual=none required=accept", k);
        end else begin
            glog.push_back(k);
            gcyc.push_back(acc);
            if (push) exp_q.push_back('{acc + lat, k, d, err});
        end
        @(posedge clk);
        #1;
        if (k == 0) req0_valid_i = 1'b0;
        else req1_valid_i = 1'b0;
    endtask

    task automatic drain();
        bit done = 0;
        for (int i = 0; i < 40 && !done; i++) begin
            @(posedge clk);
            #1;
            if (exp_q.size() == 0) done = 1;
        end
        if (!done) begin
            nchecks++;
            nfail++;
            $display("FAIL drain_timeout actual=%0d required=0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic single(input int k, input logic [2:0] op,
                          input logic [7:0] a, input logic [7:0] b,
                          input logic [15:0] d, input bit det,
                          output int acc);
        drive(k, op, a, b, d, det ? 5 : 4, 1'b0, 1'b1, acc);
        @(negedge clk);
        chk("inst_first", alu_inst_o, det ? SUB : op);
        if (det) begin
            @(negedge clk);
            chk("inst_after_detour", alu_inst_o, op);
        end
        chk("opnd_a", alu_a_o, a);
        chk("opnd_b", alu_b_o, b);
        drain();
    endtask

    initial begin
        int a0, a1, a2, a3, acc, rel;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_inst", alu_inst_o, HLD);
        chk("rst_a", alu_a_o, 0);
        chk("rst_b", alu_b_o, 0);
        chk("rst_valid", rsp_valid_o, 0);
        chk("rst_data", rsp_data_o, 0);
        chk("rst_id", rsp_id_o, 0);
        chk("rst_err", rsp_err_o, 0);
        @(posedge clk);
        #1 reset = 1'b0;

        // Both requesters contend from reset: grants alternate starting at req0.
        fork
            begin
                drive(0, ADD, 8'd1, 8'd2, 16'h0003, 4, 1'b0, 1'b1, a0);
                drive(0, XOR, 8'h0F, 8'hF0, 16'h00FF, 4, 1'b0, 1'b1, a2);
            end
            begin
                drive(1, SUB, 8'd9, 8'd4, 16'h0005, 4, 1'b0, 1'b1, a1);
                drive(1, SUB, 8'd4, 8'd9, 16'hFFFB, 4, 1'b0, 1'b1, a3);
            end
        join
        drain();
        chk("grant_order", (glog.size() == 4) ?
            {glog[0][3:0], glog[1][3:0], glog[2][3:0], glog[3][3:0]} : 16'hFFFF,
            16'h0101);
        chk("grant_gap01", a1 - a0, 4);
        chk("grant_gap12", a2 - a1, 4);
        chk("grant_gap23", a3 - a2, 4);

        single(0, ADD, 8'd3, 8'd5, 16'h0008, 1'b0, acc);
        single(0, MUL, 8'd3, 8'd4, 16'h000C, 1'b0, acc);
        single(0, NOP, 8'd1, 8'd3, 16'hFFFD, 1'b1, acc);
        single(1, SUB, 8'd20, 8'd5, 16'h000F, 1'b0, acc);

        drive(1, HLD, 8'd7, 8'd7, 16'h0000, 1, 1'b1, 1'b1, acc);
        @(negedge clk);
        chk("hold_inst", alu_inst_o, HLD);
        drain();
        single(0, ABS, 8'hFB, 8'h00, 16'h0005, 1'b0, acc);

        // Reset lands while a detoured MUL is waiting on the ALU.
        drive(0, MUL, 8'd3, 8'd3, 16'h0000, 0, 1'b0, 1'b0, acc);
        @(posedge clk);
        @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        rel = cyc;
        single(0, NOP, 8'd1, 8'd3, 16'hFFFD, 1'b0, acc);
        chk("post_reset_accept_cyc", acc, rel);

        repeat (10) @(posedge clk);
        chk("queue_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", nchecks, nfail);
        $finish;
    end

endmodule
